// File: rtl/pipeline_skid_stage.sv
// Elastic two-entry skid stage with registered upstream ready, whole-stage flush
// and per-tag selective squash of in-flight entries.
module pipeline_skid_stage #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned TAG_WIDTH  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        global_flush,
  input  logic [(1<<TAG_WIDTH)-1:0]   kill_mask,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TAG_WIDTH-1:0]        out_tag,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [1:0]                  occupancy
);

  logic                  main_valid, skid_valid;
  logic [TAG_WIDTH-1:0]  main_tag, skid_tag;
  logic [DATA_WIDTH-1:0] main_data, skid_data;
  logic                  ready_q;
  logic [1:0]            occ_q;

  logic                  main_valid_n, skid_valid_n;
  logic [TAG_WIDTH-1:0]  main_tag_n, skid_tag_n;
  logic [DATA_WIDTH-1:0] main_data_n, skid_data_n;
  logic                  ready_n;
  logic [1:0]            occ_n;

  logic in_xfer, out_xfer;

  assign in_xfer  = in_valid && ready_q;
  assign out_xfer = main_valid && out_ready;

  // Pop, kill, compaction and insert applied in sequence; pop precedes kill so a
  // delivered entry is never squashed, and invalid entries are always zeroed.
  always_comb begin
    main_valid_n = main_valid;
    main_tag_n   = main_tag;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_tag_n   = skid_tag;
    skid_data_n  = skid_data;

    if (flush || global_flush) begin
      main_valid_n = 1'b0;
      main_tag_n   = '0;
      main_data_n  = '0;
      skid_valid_n = 1'b0;
      skid_tag_n   = '0;
      skid_data_n  = '0;
    end else begin
      if (out_xfer) begin
        main_valid_n = 1'b0;
        main_tag_n   = '0;
        main_data_n  = '0;
      end

      if (main_valid_n && kill_mask[main_tag_n]) begin
        main_valid_n = 1'b0;
        main_tag_n   = '0;
        main_data_n  = '0;
      end
      if (skid_valid_n && kill_mask[skid_tag_n]) begin
        skid_valid_n = 1'b0;
        skid_tag_n   = '0;
        skid_data_n  = '0;
      end

      if (!main_valid_n && skid_valid_n) begin
        main_valid_n = 1'b1;
        main_tag_n   = skid_tag_n;
        main_data_n  = skid_data_n;
        skid_valid_n = 1'b0;
        skid_tag_n   = '0;
        skid_data_n  = '0;
      end

      // Skid is guaranteed empty here whenever a beat was accepted.
      if (in_xfer && !kill_mask[in_tag]) begin
        if (!main_valid_n) begin
          main_valid_n = 1'b1;
          main_tag_n   = in_tag;
          main_data_n  = in_data;
        end else begin
          skid_valid_n = 1'b1;
          skid_tag_n   = in_tag;
          skid_data_n  = in_data;
        end
      end
    end

    ready_n = !skid_valid_n;
    occ_n   = {1'b0, main_valid_n} + {1'b0, skid_valid_n};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_tag   <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_tag   <= '0;
      skid_data  <= '0;
      ready_q    <= 1'b1;
      occ_q      <= '0;
    end else begin
      main_valid <= main_valid_n;
      main_tag   <= main_tag_n;
      main_data  <= main_data_n;
      skid_valid <= skid_valid_n;
      skid_tag   <= skid_tag_n;
      skid_data  <= skid_data_n;
      ready_q    <= ready_n;
      occ_q      <= occ_n;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_tag   = main_tag;
  assign out_data  = main_data;
  assign occupancy = occ_q;

endmodule

// File: doc/pipeline_skid_stage.md
# pipeline_skid_stage

Parametrised elastic pipeline stage that replaces fixed stall/flush stage registers between back-end pipeline stages. It carries an opaque payload plus an active-list tag through a two-entry skid buffer under a valid/ready handshake, so it sustains full throughput with a registered upstream ready. Besides whole-stage flush, it supports selective squash of in-flight entries by tag (kill mask), so a mispredict or exception only removes younger instructions.

## Interface
Parameters:
- DATA_WIDTH, 128: payload width (packed writeback fields).
- TAG_WIDTH, 3: active-list index width; kill mask width is 2^TAG_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; one clock, no other clock domains.
- flush  input  1  local stage flush.
- global_flush  input  1  pipeline-wide flush; same effect as flush.
- kill_mask  input  2^TAG_WIDTH  bit i set = squash every entry with tag i.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept; registered, equals "skid entry empty".
- in_tag  input  TAG_WIDTH  tag of upstream beat.
- in_data  input  DATA_WIDTH  upstream payload.
- out_valid  output  1  main entry valid.
- out_ready  input  1  downstream accepts.
- out_tag  output  TAG_WIDTH  tag of main entry.
- out_data  output  DATA_WIDTH  payload of main entry.
- occupancy  output  2  number of valid entries, 0..2.

## Operation
- Two entries: MAIN (drives out_*) and SKID. MAIN is always older than SKID. SKID valid implies MAIN valid.
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- Per edge, evaluated in order:
  1. flush or global_flush: both entries invalid, tags and payloads cleared to 0; input beat that cycle discarded; an output transfer in the same cycle still counts as completed downstream.
  2. Output pop: if output transfer, MAIN is consumed. Pop beats kill: a popped entry is never squashed.
  3. Kill: each remaining entry whose kill_mask[tag] is 1 is invalidated and cleared to 0.
  4. Compaction: if MAIN is empty and SKID is valid, SKID moves to MAIN.
  5. Insert: an accepted input beat whose kill_mask[in_tag] is 0 goes to MAIN if MAIN is empty after step 4, otherwise to SKID. A beat with kill_mask[in_tag] = 1 is accepted and dropped.
- Invalid entries always hold tag 0 and data 0, so out_tag and out_data read 0 whenever out_valid = 0.
- in_ready next = SKID empty after the edge. in_ready never depends combinationally on out_ready.
- occupancy = MAIN valid + SKID valid, registered.

## Timing
- Reset values: out_valid 0, out_tag 0, out_data 0, in_ready 1, occupancy 0, both entries cleared. Reset asserted mid-transfer aborts it immediately (asynchronous). The first transfer is possible at the first edge after rst deasserts.
- Latency: 1 cycle from an accepted beat into an empty stage to out_valid.
- Throughput: 1 beat/cycle while out_ready stays 1. Occupancy stays at 1 or less and in_ready stays 1.
- Backpressure:
  - out_ready low with MAIN full: the next accepted beat fills SKID, and in_ready drops after that edge.
  - At most one extra beat is absorbed after the downstream stalls.
- Full (occupancy 2): a pop frees SKID, and in_ready rises the cycle after the pop. A simultaneous in_valid is not accepted that cycle because in_ready is 0.
- Empty: out_valid 0. A simultaneous push and kill of a different tag is unaffected.
- Kill of MAIN only with SKID valid: SKID is promoted the same edge, so the next out_* shows the SKID beat.
- flush together with any kill_mask or handshake: flush wins, result is empty.

## Test plan
- Streaming: out_ready=1, push tags 0..7 with data 0x10..0x17 on consecutive cycles -> out_valid from cycle 1, out_data 0x10..0x17 in order, in_ready constantly 1, occupancy never exceeds 1.
- Backpressure: hold out_ready=0, push A(tag1) and B(tag2) -> occupancy=2, in_ready=0. A third beat C is not taken. Raise out_ready -> A, B, C emerge in order with none lost or duplicated.
- Selective kill: MAIN=tag3, SKID=tag4, kill_mask=0b00001000, out_ready=0 -> next cycle out_tag=4, occupancy=1, in_ready=1.
- Kill vs pop and kill on entry: MAIN=tag5, out_ready=1, kill_mask bit5 set -> the tag5 beat is counted as delivered. A same-cycle in_valid with tag5 is dropped and occupancy goes to 0.
- Flush: occupancy 2, assert global_flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_data=0, in_ready=1, and the incoming beat is lost.
- Async reset: assert rst between clock edges with occupancy 2 -> outputs reach reset values before the next edge. After deassert, a push appears at out_* one cycle later.
